wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Initiator side of the register-file write port. It owns rf_we/rf_rd/rf_wd.
//  It merges single-cycle ALU results with late, variable-latency load responses.
//  Load responses are buffered in a small queue. Load data is aligned and
//  sign/zero-extended before writeback.
//  It keeps a pending-load scoreboard, which decode queries for RAW/WAW stalls.
// PARAMETERS
//  XLEN      32  datapath width
//  LQ_DEPTH  4   load-response queue entries; power of 2, >=2
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  alu_valid    in   1     ALU result present this cycle; never back-pressured
//  alu_rd       in   5     ALU destination register
//  alu_wd       in   XLEN  ALU result
//  ld_issue     in   1     load issued to memory this cycle
//  ld_issue_rd  in   5     destination of the issued load
//  ld_valid     in   1     memory load response valid
//  ld_ready     out  1     queue can accept a response; = !full (registered count)
//  ld_rd        in   5     response destination register
//  ld_funct3    in   3     LB=000 LH=001 LW=010 LBU=100 LHU=101
//  ld_addr_lo   in   2     byte offset of the access
//  ld_rdata     in   XLEN  raw aligned-word read data
//  dec_rs1      in   5     decode source 1 query
//  dec_rs2      in   5     decode source 2 query
//  dec_rd       in   5     decode destination query
//  dec_stall    out  1     combinational: a queried register (non-x0) is pending
//  rf_we        out  1     register-file write enable (registered)
//  rf_rd        out  5     register-file write address (registered)
//  rf_wd        out  XLEN  register-file write data (registered)
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - rf_we=0, rf_rd=0, rf_wd=0.
//    - Queue emptied; ld_ready=1; scoreboard all 0.
//    - Reset mid-operation discards all queued and in-flight loads.
//  - Handshake: a response is accepted when ld_valid && ld_ready.
//    - Accepted responses are never dropped.
//    - ld_rd=0 responses are accepted and discarded: no write, no queue entry.
//  - Writeback source each cycle, priority order:
//    1. alu_valid (alu_rd != 0)
//    2. queue head
//    3. incoming accepted response, only when the queue is empty (fall-through)
//  - A response not selected is pushed. Push and pop may occur in the same cycle.
//  - Latency: the selected source appears on rf_* one cycle later.
//    Minimum ALU-to-rf_we latency = 1; minimum ld_valid-to-rf_we latency = 1.
//  - rf_we=0 when nothing is selected. rf_rd/rf_wd hold their last value.
//  - Load extension. The byte/half is taken at ld_addr_lo*8.
//    - LB/LH: sign-extend to XLEN.
//    - LBU/LHU: zero-extend to XLEN.
//    - LW: the full word; ld_addr_lo ignored.
//    - Other funct3 values: treat as LW.
//  - Queue entry = {rd, funct3, addr_lo, rdata}. Extension is applied at pop/select.
//  - Count occupancy with a wrap-around pointer plus an extra bit.
//    full = (count == LQ_DEPTH).
//  - Scoreboard pend[31:0]:
//    - Set on ld_issue with ld_issue_rd != 0.
//    - Cleared on the edge at which that load's writeback is registered onto rf_*.
//      The regfile write-through bypass covers the write cycle.
//    - pend[0] is always 0.
//    - Same-cycle set and clear of different regs: both apply.
//      Same reg cannot occur, because dec_stall blocks it.
//  - dec_stall = pend[dec_rs1] | pend[dec_rs2] | pend[dec_rd]; x0 queries never stall.
//  - ALU priority and starvation. Decode guarantees an ALU op never targets a pending reg.
//    A queued load waits only while alu_valid is high back-to-back.
//  - Simultaneous ld_valid with a full queue: ld_ready=0, so the response is not
//    accepted and memory holds it.
// STRUCTURE
//  - Shared package rv_pkg: load funct3 enum (LB/LH/LW/LBU/LHU), XLEN,
//    REG_ADDR_W=5, typedef lq_entry_t.
//  - One sub-module: wb_lq_fifo. Parameterised synchronous FIFO with async
//    active-low reset and full/empty/count outputs.
//  - Extension logic: a function in rv_pkg (load_extend).
// TESTING
//  1. Reset: pulse rst_n low mid-traffic.
//     -> rf_we=0 immediately; ld_ready=1; dec_stall=0 for all queries.
//  2. ALU only: alu_valid, rd=5, wd=0xDEADBEEF.
//     -> next cycle rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF; rd=0 -> rf_we stays 0.
//  3. Extension: rdata=0x80FF7F01.
//     - LB off1 -> 0x0000007F.
//     - LB off3 -> 0xFFFFFF80.
//     - LHU off2 -> 0x000080FF.
//     - LH off2 -> 0xFFFF80FF.
//     - LW -> 0x80FF7F01.
//  4. Collision: alu_valid(rd=3) and ld_valid(rd=7) same cycle.
//     -> x3 written at T+1, x7 at T+2; no loss.
//  5. Back-pressure: hold alu_valid 6 cycles while sending 5 load responses.
//     -> ld_ready=0 after 4 accepted; all 4 drained in order afterwards;
//        5th accepted once ld_ready=1.
//  6. Scoreboard: ld_issue rd=9, then dec_rs1=9 -> dec_stall=1 until the cycle
//     rf_we writes x9; dec_rs1=0 never stalls.

Source files
------------

// File: rtl/rv_pkg.sv
// Purpose: shared types and helpers for load writeback (funct3 codes, queue entry, extension).
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package rv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } ld_funct3_e;

   // One buffered load response. Data is kept raw; extension happens when it
   // is selected for writeback.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [2:0]            funct3;
      logic [1:0]            addr_lo;
      logic [XLEN-1:0]       rdata;
   } lq_entry_t;

   // Align the addressed byte/half down to bit 0, then sign- or zero-extend.
   // Unknown funct3 codes fall back to a full-word load.
   function automatic logic [XLEN-1:0] load_extend(input lq_entry_t e);
      logic [XLEN-1:0] sh;
      sh = e.rdata >> {e.addr_lo, 3'b000};
      case (e.funct3)
         LB:      load_extend = {{(XLEN-8){sh[7]}}, sh[7:0]};
         LH:      load_extend = {{(XLEN-16){sh[15]}}, sh[15:0]};
         LBU:     load_extend = {{(XLEN-8){1'b0}}, sh[7:0]};
         LHU:     load_extend = {{(XLEN-16){1'b0}}, sh[15:0]};
         default: load_extend = e.rdata;
      endcase
   endfunction

endpackage

// File: rtl/wb_lq_fifo.sv
// Purpose: small synchronous FIFO holding load responses awaiting writeback.
// Latency: pushed word visible at pop_dat the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; caller gates on full/empty.
//
// Ports: clk/rst_n; push/push_dat write side; pop/pop_dat read side (pop_dat
// is the current head); full/empty/count occupancy status.
module wb_lq_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             pop_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra bit so full and empty are distinguishable.
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];

   assign count   = wr_ptr_q - rd_ptr_q;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (push && !full) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_dat;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Purpose: register-file write port arbiter merging ALU results and queued load responses.
// Latency: selected source appears on rf_* one cycle later (ALU and fall-through load alike).
// Backpressure: ALU never stalled; loads back-pressured via ld_ready = !full of the response queue.
//
// Ports: alu_* single-cycle results; ld_issue/ld_issue_rd mark a load in
// flight; ld_valid/ld_ready/ld_* memory response; dec_* decode hazard query
// with dec_stall answer; rf_we/rf_rd/rf_wd registered write port.
// XLEN must match rv_pkg::XLEN, which sizes the queue entry.
module wb_arbiter #(
   parameter int XLEN     = rv_pkg::XLEN,
   parameter int LQ_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_wd,
   input  logic            ld_issue,
   input  logic [4:0]      ld_issue_rd,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [4:0]      ld_rd,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_addr_lo,
   input  logic [XLEN-1:0] ld_rdata,
   input  logic [4:0]      dec_rs1,
   input  logic [4:0]      dec_rs2,
   input  logic [4:0]      dec_rd,
   output logic            dec_stall,
   output logic            rf_we,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_wd
);

   import rv_pkg::*;

   localparam int CW = $clog2(LQ_DEPTH) + 1;

   lq_entry_t             in_ent, head_ent, sel_ent;
   logic                  lq_full, lq_empty, lq_push, lq_pop;
   logic [CW-1:0]         lq_count;
   logic                  ld_acc, ld_keep, alu_sel, ld_sel;

   logic                  rf_we_q, rf_we_d;
   logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
   logic [XLEN-1:0]       rf_wd_q, rf_wd_d;
   logic [31:0]           pend_q, pend_d;

   assign ld_ready = !lq_full;
   assign ld_acc   = ld_valid && ld_ready;
   // Responses to x0 are consumed here and never reach the queue.
   assign ld_keep  = ld_acc && (ld_rd != '0);
   assign alu_sel  = alu_valid && (alu_rd != '0);
   assign in_ent   = {ld_rd, ld_funct3, ld_addr_lo, ld_rdata};

   wb_lq_fifo #(
      .W     ($bits(lq_entry_t)),
      .DEPTH (LQ_DEPTH)
   ) u_lq (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (lq_push),
      .push_dat (in_ent),
      .pop      (lq_pop),
      .pop_dat  (head_ent),
      .full     (lq_full),
      .empty    (lq_empty),
      .count    (lq_count)
   );

   // Occupancy can never exceed the queue size.
   always_comb assert (lq_count <= CW'(LQ_DEPTH));

   always_comb begin
      lq_push = 1'b0;
      lq_pop  = 1'b0;
      ld_sel  = 1'b0;
      sel_ent = head_ent;
      rf_we_d = 1'b0;
      rf_rd_d = rf_rd_q;
      rf_wd_d = rf_wd_q;

      if (alu_sel) begin
         rf_we_d = 1'b1;
         rf_rd_d = alu_rd;
         rf_wd_d = alu_wd;
         lq_push = ld_keep;
      end else if (!lq_empty) begin
         // Older queued responses go first so write order matches arrival.
         lq_pop  = 1'b1;
         ld_sel  = 1'b1;
         lq_push = ld_keep;
      end else if (ld_keep) begin
         // Empty queue: bypass straight to the write port.
         ld_sel  = 1'b1;
         sel_ent = in_ent;
      end

      if (ld_sel) begin
         rf_we_d = 1'b1;
         rf_rd_d = sel_ent.rd;
         rf_wd_d = load_extend(sel_ent);
      end

      // Clear at the edge the load's write is registered; the regfile bypass
      // covers the following write cycle. Decode prevents set/clear of the
      // same register in one cycle.
      pend_d = pend_q;
      if (ld_sel)   pend_d[sel_ent.rd]  = 1'b0;
      if (ld_issue) pend_d[ld_issue_rd] = 1'b1;
      pend_d[0] = 1'b0;
   end

   // pend_q[0] is held at 0, so x0 queries never stall.
   assign dec_stall = pend_q[dec_rs1] | pend_q[dec_rs2] | pend_q[dec_rd];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_q <= 1'b0;
         rf_rd_q <= '0;
         rf_wd_q <= '0;
         pend_q  <= '0;
      end else begin
         rf_we_q <= rf_we_d;
         rf_rd_q <= rf_rd_d;
         rf_wd_q <= rf_wd_d;
         pend_q  <= pend_d;
      end
   end

   assign rf_we = rf_we_q;
   assign rf_rd = rf_rd_q;
   assign rf_wd = rf_wd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Purpose: bench for wb_arbiter: directed stimulus, queue-based reference model, literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, ld_issue, ld_valid, ld_ready, dec_stall, rf_we;
   logic [4:0]  alu_rd, ld_issue_rd, ld_rd, dec_rs1, dec_rs2, dec_rd, rf_rd;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_addr_lo;
   logic [31:0] alu_wd, ld_rdata, rf_wd;

   always #5 clk = ~clk;

   wb_arbiter #(.XLEN(32), .LQ_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd),
      .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
      .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .ld_rdata(ld_rdata),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_stall(dec_stall),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h want=%08h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] d;
   } resp_t;

   resp_t       mq[$];
   bit          m_pend[32];
   logic        m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_wd;

   function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] d);
      int unsigned v;
      int unsigned sh;
      sh = 8 * int'(off);
      case (f3)
         3'b000: begin v = (d >> sh) & 32'hFF;   if (v >= 128)   v = v + 32'hFFFFFF00; end
         3'b001: begin v = (d >> sh) & 32'hFFFF; if (v >= 32768) v = v + 32'hFFFF0000; end
         3'b100: v = (d >> sh) & 32'hFF;
         3'b101: v = (d >> sh) & 32'hFFFF;
         default: v = d;
      endcase
      return v;
   endfunction

   // Inputs change only at the falling edge; compare and advance the model
   // slightly after, once combinational outputs have settled.
   always @(negedge clk) begin
      resp_t r;
      bit    exp_stall;
      bit    has_room;
      #2;
      if (!rst_n) begin
         mq.delete();
         foreach (m_pend[i]) m_pend[i] = 1'b0;
         m_we = 1'b0;
         m_rd = '0;
         m_wd = '0;
      end
      has_room  = (mq.size() < 4);
      exp_stall = (dec_rs1 != 0 && m_pend[dec_rs1]) || (dec_rs2 != 0 && m_pend[dec_rs2]) ||
                  (dec_rd != 0 && m_pend[dec_rd]);
      chk("mon_rf_we", rf_we, m_we);
      chk("mon_rf_rd", rf_rd, m_rd);
      chk("mon_rf_wd", rf_wd, m_wd);
      chk("mon_ld_ready", ld_ready, has_room);
      chk("mon_dec_stall", dec_stall, exp_stall);
      if (rst_n) begin
         if (ld_valid && has_room && ld_rd != 0) begin
            r.rd = ld_rd; r.f3 = ld_funct3; r.off = ld_addr_lo; r.d = ld_rdata;
            mq.push_back(r);
         end
         if (alu_valid && alu_rd != 0) begin
            m_we = 1'b1; m_rd = alu_rd; m_wd = alu_wd;
         end else if (mq.size() > 0) begin
            r = mq.pop_front();
            m_we = 1'b1; m_rd = r.rd; m_wd = m_ext(r.f3, r.off, r.d);
            m_pend[r.rd] = 1'b0;
         end else begin
            m_we = 1'b0;
         end
         if (ld_issue && ld_issue_rd != 0) m_pend[ld_issue_rd] = 1'b1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic nc();
      @(negedge clk);
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      ld_issue  = 1'b0;
   endtask

   task automatic send_alu(input logic [4:0] rd, input logic [31:0] d);
      alu_valid = 1'b1; alu_rd = rd; alu_wd = d;
   endtask

   task automatic send_ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                          input logic [31:0] d);
      ld_valid = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = off; ld_rdata = d;
   endtask

   logic [2:0]  ext_f3  [7] = '{3'b000, 3'b000, 3'b101, 3'b001, 3'b010, 3'b111, 3'b100};
   logic [1:0]  ext_off [7] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd1, 2'd2, 2'd3};
   logic [31:0] ext_exp [7] = '{32'h0000007F, 32'hFFFFFF80, 32'h000080FF, 32'hFFFF80FF,
                                32'h80FF7F01, 32'h80FF7F01, 32'h00000080};

   initial begin
      int sent;
      rst_n = 1'b0;
      alu_valid = 0; alu_rd = 0; alu_wd = 0;
      ld_issue = 0; ld_issue_rd = 0;
      ld_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0; ld_rdata = 0;
      dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;

      nc(); #1;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_ld_ready", ld_ready, 1);
      nc(); rst_n = 1'b1;

      // Reset mid-traffic: queue holds two loads and x14 is pending.
      nc(); ld_issue = 1; ld_issue_rd = 14; send_alu(1, 32'h11); send_ld(15, 3'b010, 0, 32'hAAAA0015);
      nc(); send_alu(2, 32'h22); send_ld(16, 3'b010, 0, 32'hAAAA0016); dec_rs1 = 14; #1;
      chk("pre_rst_stall", dec_stall, 1);
      chk("pre_rst_we", rf_we, 1);
      nc(); rst_n = 1'b0; #1;
      chk("midrst_we", rf_we, 0);
      chk("midrst_ready", ld_ready, 1);
      chk("midrst_stall", dec_stall, 0);
      nc(); rst_n = 1'b1; dec_rs1 = 0;
      nc(); nc(); #1;
      chk("post_rst_no_write", rf_we, 0);

      // ALU only, then rd=0 ALU and rd=0 load are both dropped.
      nc(); send_alu(5, 32'hDEADBEEF);
      nc(); send_alu(0, 32'h12345678); #1;
      chk("alu_we", rf_we, 1);
      chk("alu_rd", rf_rd, 5);
      chk("alu_wd", rf_wd, 32'hDEADBEEF);
      nc(); send_ld(0, 3'b010, 0, 32'hCAFE); #1;
      chk("alu_x0_we", rf_we, 0);
      chk("alu_x0_rd_hold", rf_rd, 5);
      nc(); #1;
      chk("ld_x0_we", rf_we, 0);
      chk("ld_x0_wd_hold", rf_wd, 32'hDEADBEEF);

      // Load extension through the fall-through path.
      for (int i = 0; i < 7; i++) begin
         nc(); send_ld(5'(10 + i), ext_f3[i], ext_off[i], 32'h80FF7F01);
         nc(); #1;
         chk("ext_we", rf_we, 1);
         chk("ext_rd", rf_rd, 10 + i);
         chk("ext_wd", rf_wd, ext_exp[i]);
      end

      // ALU/load collision.
      nc(); send_alu(3, 32'h3333); send_ld(7, 3'b010, 0, 32'h7777);
      nc(); #1;
      chk("col_t1_rd", rf_rd, 3);
      chk("col_t1_wd", rf_wd, 32'h3333);
      nc(); #1;
      chk("col_t2_we", rf_we, 1);
      chk("col_t2_rd", rf_rd, 7);
      chk("col_t2_wd", rf_wd, 32'h7777);

      // Back-pressure: ALU held 6 cycles, 5 responses offered.
      sent = 0;
      for (int c = 0; c < 12; c++) begin
         nc();
         if (c < 6) send_alu(5'(10 + c), 32'h2000 + c);
         if (sent < 5) send_ld(5'(24 + sent), 3'b010, 0, 32'h100 + sent);
         #1;
         if (c >= 4 && c <= 6) chk("bp_ready_low", ld_ready, 0);
         if (c == 7) chk("bp_ready_back", ld_ready, 1);
         if (c >= 7) begin
            chk("bp_drain_rd", rf_rd, 24 + (c - 7));
            chk("bp_drain_wd", rf_wd, 32'h100 + (c - 7));
         end
         if (ld_valid && ld_ready) sent++;
      end
      chk("bp_all_accepted", sent, 5);

      // Scoreboard.
      nc(); ld_issue = 1; ld_issue_rd = 9; dec_rs1 = 9; #1;
      chk("sb_before_set", dec_stall, 0);
      nc(); #1;
      chk("sb_rs1", dec_stall, 1);
      nc(); dec_rs1 = 0; dec_rs2 = 9; #1;
      chk("sb_rs2", dec_stall, 1);
      nc(); dec_rs2 = 0; dec_rd = 9; #1;
      chk("sb_rd", dec_stall, 1);
      nc(); dec_rd = 0; ld_issue = 1; ld_issue_rd = 0; #1;
      chk("sb_x0_query", dec_stall, 0);
      nc(); dec_rs1 = 9; send_ld(9, 3'b010, 0, 32'h9999); #1;
      chk("sb_resp_cycle", dec_stall, 1);
      nc(); #1;
      chk("sb_wb_we", rf_we, 1);
      chk("sb_wb_rd", rf_rd, 9);
      chk("sb_cleared", dec_stall, 0);

      nc(); dec_rs1 = 0;
      nc(); nc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
